// File: rtl/game_pkg.sv
// Shared move encoding and button ordering used by the input front-end and the game FSM.
package game_pkg;

  localparam int unsigned DIR_W   = 2;
  localparam int unsigned NUM_BTN = 4;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'd0;
  localparam dir_t DIR_LEFT  = 2'd1;
  localparam dir_t DIR_UP    = 2'd2;
  localparam dir_t DIR_DOWN  = 2'd3;

  // Button vector order is {down, up, left, right}, so bit index equals direction code
  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_UP    = 2;
  localparam int unsigned BTN_DOWN  = 3;

  // Lowest set bit wins: RIGHT > LEFT > UP > DOWN
  function automatic dir_t prio_dir(input logic [NUM_BTN-1:0] pulses);
    dir_t d;
    d = DIR_RIGHT;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pulses[i]) d = DIR_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/move_cmd_frontend_btn_cond.sv
// One button: 2-flop synchroniser, debounce counter and registered press pulse.
module btn_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 != level) begin
        if (cnt_q == CNT_LAST) begin
          level <= ~level;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/move_cmd_frontend.sv
// Turns four raw direction buttons into arbitrated, buffered move commands
// delivered over a valid/ready handshake.
module move_cmd_frontend
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       right,
  input  logic       left,
  input  logic       up,
  input  logic       down,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  output logic [3:0] btn_level,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] level;

  assign raw_btn   = {down, up, left, right};
  assign btn_level = level;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_cond #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_cond (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_btn[g]),
      .level(level[g]),
      .press(press[g])
    );
  end

  dir_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic               win_valid_c;
  dir_t               win_dir_c;
  logic [NUM_BTN-1:0] win_onehot_c;
  logic               lose_c;
  logic               pop_c;
  logic               full_c;
  logic               push_c;
  logic               drop_c;
  logic [CNT_W-1:0]   count_nxt_c;
  logic [PTR_W-1:0]   wr_ptr_nxt_c;
  logic [PTR_W-1:0]   rd_ptr_nxt_c;
  dir_t               mem_nxt_c [FIFO_DEPTH];
  dir_t               cmd_dir_nxt_c;

  // Arbitration, FIFO next state and the next head entry for the registered outputs
  always_comb begin
    win_valid_c  = |press;
    win_dir_c    = prio_dir(press);
    win_onehot_c = press & (~press + NUM_BTN'(1));
    lose_c       = |(press & ~win_onehot_c);

    pop_c  = cmd_valid & cmd_ready;
    full_c = (count_q == CNT_W'(FIFO_DEPTH));
    push_c = win_valid_c & (~full_c | pop_c);
    drop_c = win_valid_c & full_c & ~pop_c;

    count_nxt_c  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_nxt_c = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_nxt_c = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    mem_nxt_c = mem_q;
    if (push_c) mem_nxt_c[wr_ptr_q] = win_dir_c;

    cmd_dir_nxt_c = DIR_RIGHT;
    if (count_nxt_c != '0) cmd_dir_nxt_c = mem_nxt_c[rd_ptr_nxt_c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= DIR_RIGHT;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cmd_valid <= 1'b0;
      cmd_dir   <= DIR_RIGHT;
      overflow  <= 1'b0;
    end else begin
      mem_q     <= mem_nxt_c;
      wr_ptr_q  <= wr_ptr_nxt_c;
      rd_ptr_q  <= rd_ptr_nxt_c;
      count_q   <= count_nxt_c;
      cmd_valid <= (count_nxt_c != '0);
      cmd_dir   <= cmd_dir_nxt_c;
      overflow  <= overflow | drop_c | lose_c;
    end
  end

endmodule

// File: tb/tb_move_cmd_frontend.sv
// Directed bench for move_cmd_frontend with DEBOUNCE_CYCLES=4, FIFO_DEPTH=2.
module tb_move_cmd_frontend;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       right, left, up, down;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic [3:0] btn_level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  move_cmd_frontend #(
    .DEBOUNCE_CYCLES(DEB),
    .FIFO_DEPTH     (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .right    (right),
    .left     (left),
    .up       (up),
    .down     (down),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .btn_level(btn_level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens on the falling edge
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: right = v;
      1: left  = v;
      2: up    = v;
      default: down = v;
    endcase
  endtask

  // Press long enough to enqueue, then release long enough to settle
  task automatic press_release(input int idx);
    set_btn(idx, 1'b1);
    step(DEB + 4);
    set_btn(idx, 1'b0);
    step(DEB + 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; right = 0; left = 0; up = 0; down = 0; cmd_ready = 0;
    step(3);
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_dir",   32'(cmd_dir),   0);
    check("rst_level", 32'(btn_level), 0);
    check("rst_ovf",   32'(overflow),  0);
    rst = 1'b0;

    // Single right press: level after edge 6, command after edge 8
    right = 1;
    step(DEB + 1);
    check("t1_level_e5", 32'(btn_level), 0);
    step(1);
    check("t1_level_e6", 32'(btn_level), 32'h1);
    step(1);
    check("t1_valid_e7", 32'(cmd_valid), 0);
    step(1);
    check("t1_valid_e8", 32'(cmd_valid), 1);
    check("t1_dir_e8",   32'(cmd_dir),   0);
    cmd_ready = 1;
    step(1);
    cmd_ready = 0;
    check("t1_popped", 32'(cmd_valid), 0);
    step(12);
    check("t1_no_repeat", 32'(cmd_valid), 0);
    right = 0;
    step(DEB + 4);
    check("t1_release_nocmd", 32'(cmd_valid), 0);
    check("t1_release_level", 32'(btn_level), 0);

    // Glitchy left toggling every cycle never debounces
    for (int i = 0; i < 20; i++) begin
      left = ~left;
      step(1);
    end
    left = 0;
    step(DEB + 4);
    check("t2_level", 32'(btn_level), 0);
    check("t2_valid", 32'(cmd_valid), 0);
    check("t2_ovf",   32'(overflow),  0);

    // Simultaneous up+down: up wins, down is lost
    up = 1; down = 1;
    step(DEB + 4);
    check("t3_valid", 32'(cmd_valid), 1);
    check("t3_dir",   32'(cmd_dir),   2);
    check("t3_ovf",   32'(overflow),  1);
    check("t3_level", 32'(btn_level), 32'hc);
    cmd_ready = 1;
    step(1);
    cmd_ready = 0;
    check("t3_single", 32'(cmd_valid), 0);
    up = 0; down = 0;
    step(DEB + 4);

    // Full FIFO with push and pop on the same edge
    do_reset();
    check("t5_ovf_rst", 32'(overflow), 0);
    press_release(0);
    press_release(1);
    check("t5_full_valid", 32'(cmd_valid), 1);
    check("t5_full_dir",   32'(cmd_dir),   0);
    down = 1;
    step(DEB + 3);
    cmd_ready = 1;
    step(1);
    cmd_ready = 0;
    check("t5_pp_valid", 32'(cmd_valid), 1);
    check("t5_pp_dir",   32'(cmd_dir),   1);
    check("t5_pp_ovf",   32'(overflow),  0);
    cmd_ready = 1;
    step(1);
    check("t5_tail_dir", 32'(cmd_dir), 3);
    step(1);
    cmd_ready = 0;
    check("t5_empty", 32'(cmd_valid), 0);
    check("t5_empty_dir", 32'(cmd_dir), 0);
    down = 0;
    step(DEB + 4);

    // Three presses into a 2-deep FIFO: third is dropped
    press_release(0);
    press_release(1);
    press_release(3);
    check("t4_valid", 32'(cmd_valid), 1);
    check("t4_dir0",  32'(cmd_dir),   0);
    check("t4_ovf",   32'(overflow),  1);
    cmd_ready = 1;
    step(1);
    check("t4_valid1", 32'(cmd_valid), 1);
    check("t4_dir1",   32'(cmd_dir),   1);
    step(1);
    cmd_ready = 0;
    check("t4_drained", 32'(cmd_valid), 0);

    // Reset with two buffered commands and right held
    press_release(0);
    press_release(1);
    check("t6_buffered", 32'(cmd_valid), 1);
    right = 1;
    step(2);
    rst = 1;
    step(1);
    check("t6_rst_valid", 32'(cmd_valid), 0);
    check("t6_rst_dir",   32'(cmd_dir),   0);
    check("t6_rst_level", 32'(btn_level), 0);
    check("t6_rst_ovf",   32'(overflow),  0);
    rst = 0;
    step(DEB + 2);
    check("t6_level_e6", 32'(btn_level), 32'h1);
    step(1);
    check("t6_valid_e7", 32'(cmd_valid), 0);
    step(1);
    check("t6_valid_e8", 32'(cmd_valid), 1);
    check("t6_dir_e8",   32'(cmd_dir),   0);
    cmd_ready = 1;
    step(1);
    check("t6_popped", 32'(cmd_valid), 0);
    step(10);
    check("t6_only_one", 32'(cmd_valid), 0);
    cmd_ready = 0;
    right = 0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
